// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths, writeback request record and requester identifiers for the
// register-file writeback arbiter.
package rf_wb_arbiter_pkg;

   localparam int XLEN    = 32;
   localparam int RADDR_W = 5;

   typedef struct packed {
      logic [RADDR_W-1:0] rd;
      logic [XLEN-1:0]    data;
   } wb_req_t;

   typedef enum logic {
      SRC_EX = 1'b0,
      SRC_LD = 1'b1
   } wb_src_e;

   // x0 is never pending because it is never written.
   function automatic logic hitsReg(input logic               slotValid,
                                    input logic [RADDR_W-1:0] slotRd,
                                    input logic [RADDR_W-1:0] rs);
      return slotValid && (slotRd == rs) && (rs != '0);
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_hold_slot.sv
// One-entry valid/ready holding register for a writeback requester. Requests
// to x0 are handshaked normally but never occupy the slot.
module rf_wb_arbiter_hold_slot
   import rf_wb_arbiter_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [RADDR_W-1:0] rd_i,
   input  logic [XLEN-1:0]    data_i,
   input  logic               grant_i,
   output logic               load_o,
   output logic               slotValid_o,
   output logic [RADDR_W-1:0] slotRd_o,
   output logic [XLEN-1:0]    slotData_o
);

   logic    valid_q, valid_d;
   wb_req_t req_q, req_d;

   // A slot draining this cycle can be refilled at the same edge.
   assign ready_o = ~valid_q | grant_i;
   assign load_o  = valid_i & ready_o & (rd_i != '0);

   always_comb begin
      valid_d = valid_q;
      req_d   = req_q;
      if (load_o) begin
         valid_d = 1'b1;
         req_d   = '{rd: rd_i, data: data_i};
      end else if (grant_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         req_q   <= '0;
      end else begin
         valid_q <= valid_d;
         req_q   <= req_d;
      end
   end

   assign slotValid_o = valid_q;
   assign slotRd_o    = req_q.rd;
   assign slotData_o  = req_q.data;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port between the EX and LD writeback
// requesters and reports held writes so decode can stall dependent reads.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               ex_valid_i,
   output logic               ex_ready_o,
   input  logic [RADDR_W-1:0] ex_rd_i,
   input  logic [XLEN-1:0]    ex_data_i,
   input  logic               ld_valid_i,
   output logic               ld_ready_o,
   input  logic [RADDR_W-1:0] ld_rd_i,
   input  logic [XLEN-1:0]    ld_data_i,
   output logic               reg_wen_o,
   output logic [RADDR_W-1:0] rd_o,
   output logic [XLEN-1:0]    rd_data_o,
   input  logic [RADDR_W-1:0] rs1_i,
   input  logic [RADDR_W-1:0] rs2_i,
   output logic               rs1_pend_o,
   output logic               rs2_pend_o
);

   logic               exSlotValid, ldSlotValid;
   logic [RADDR_W-1:0] exSlotRd, ldSlotRd;
   logic [XLEN-1:0]    exSlotData, ldSlotData;
   logic               exLoad, ldLoad;
   logic               grantEx, grantLd;
   wb_src_e            rrPtr_q, rrPtr_d;
   logic               ldOlder_q, ldOlder_d;

   rf_wb_arbiter_hold_slot u_exSlot (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .valid_i     (ex_valid_i),
      .ready_o     (ex_ready_o),
      .rd_i        (ex_rd_i),
      .data_i      (ex_data_i),
      .grant_i     (grantEx),
      .load_o      (exLoad),
      .slotValid_o (exSlotValid),
      .slotRd_o    (exSlotRd),
      .slotData_o  (exSlotData)
   );

   rf_wb_arbiter_hold_slot u_ldSlot (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .valid_i     (ld_valid_i),
      .ready_o     (ld_ready_o),
      .rd_i        (ld_rd_i),
      .data_i      (ld_data_i),
      .grant_i     (grantLd),
      .load_o      (ldLoad),
      .slotValid_o (ldSlotValid),
      .slotRd_o    (ldSlotRd),
      .slotData_o  (ldSlotData)
   );

   // Same destination must retire in program order, so age beats round-robin.
   always_comb begin
      grantEx = 1'b0;
      grantLd = 1'b0;
      if (exSlotValid && ldSlotValid) begin
         if (exSlotRd == ldSlotRd) begin
            if (ldOlder_q) grantLd = 1'b1;
            else           grantEx = 1'b1;
         end else if (rrPtr_q == SRC_EX) begin
            grantEx = 1'b1;
         end else begin
            grantLd = 1'b1;
         end
      end else if (exSlotValid) begin
         grantEx = 1'b1;
      end else if (ldSlotValid) begin
         grantLd = 1'b1;
      end
   end

   // A simultaneous capture counts LD as older, hence EX load wins the tie.
   always_comb begin
      rrPtr_d   = rrPtr_q;
      ldOlder_d = ldOlder_q;
      if (exSlotValid && ldSlotValid) begin
         rrPtr_d = grantEx ? SRC_LD : SRC_EX;
      end
      if (exLoad) begin
         ldOlder_d = 1'b1;
      end else if (ldLoad) begin
         ldOlder_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rrPtr_q   <= SRC_EX;
         ldOlder_q <= 1'b0;
      end else begin
         rrPtr_q   <= rrPtr_d;
         ldOlder_q <= ldOlder_d;
      end
   end

   always_comb begin
      reg_wen_o = 1'b1;
      rd_o      = '0;
      rd_data_o = '0;
      if (grantEx) begin
         reg_wen_o = 1'b0;
         rd_o      = exSlotRd;
         rd_data_o = exSlotData;
      end else if (grantLd) begin
         reg_wen_o = 1'b0;
         rd_o      = ldSlotRd;
         rd_data_o = ldSlotData;
      end
   end

   // The slot draining this cycle still counts: the regfile updates at the edge.
   assign rs1_pend_o = hitsReg(exSlotValid, exSlotRd, rs1_i) | hitsReg(ldSlotValid, ldSlotRd, rs1_i);
   assign rs2_pend_o = hitsReg(exSlotValid, exSlotRd, rs2_i) | hitsReg(ldSlotValid, ldSlotRd, rs2_i);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single write, round-robin,
// same-register ordering, x0 drop, streaming throughput and mid-stream reset.
module tb_rf_wb_arbiter;

   logic        clk;
   logic        rstN;
   logic        exValid, exReady, ldValid, ldReady;
   logic [4:0]  exRd, ldRd, rd, rs1, rs2;
   logic [31:0] exData, ldData, rdData;
   logic        regWen, rs1Pend, rs2Pend;
   int          errors;
   int          checks;

   rf_wb_arbiter dut (
      .clk_i      (clk),
      .rst_ni     (rstN),
      .ex_valid_i (exValid),
      .ex_ready_o (exReady),
      .ex_rd_i    (exRd),
      .ex_data_i  (exData),
      .ld_valid_i (ldValid),
      .ld_ready_o (ldReady),
      .ld_rd_i    (ldRd),
      .ld_data_i  (ldData),
      .reg_wen_o  (regWen),
      .rd_o       (rd),
      .rd_data_o  (rdData),
      .rs1_i      (rs1),
      .rs2_i      (rs2),
      .rs1_pend_o (rs1Pend),
      .rs2_pend_o (rs2Pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reset holds both slots empty; pending lookups on real registers stay low.
   task automatic test_reset();
      rstN = 1'b0; exValid = 1'b0; ldValid = 1'b0;
      exRd = '0; ldRd = '0; exData = '0; ldData = '0; rs1 = 5'd5; rs2 = 5'd7;
      repeat (2) @(posedge clk);
      #1 rstN = 1'b1;
      @(negedge clk);
      checks++; if (regWen !== 1'b1) begin errors++; $display("[TB] FAIL reset_wen: got %b expected 1", regWen); end
      checks++; if (rd !== 5'd0) begin errors++; $display("[TB] FAIL reset_rd: got %0d expected 0", rd); end
      checks++; if (rdData !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", rdData); end
      checks++; if (exReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ex_ready: got %b expected 1", exReady); end
      checks++; if (ldReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ld_ready: got %b expected 1", ldReady); end
      checks++; if (rs1Pend !== 1'b0) begin errors++; $display("[TB] FAIL reset_rs1_pend: got %b expected 0", rs1Pend); end
      checks++; if (rs2Pend !== 1'b0) begin errors++; $display("[TB] FAIL reset_rs2_pend: got %b expected 0", rs2Pend); end
   endtask

   task automatic test_single_write();
      @(posedge clk);
      #1 exValid = 1'b1; exRd = 5'd5; exData = 32'hA5A5_0001; rs1 = 5'd5;
      @(posedge clk);
      #1 exValid = 1'b0;
      @(negedge clk);
      checks++; if (regWen !== 1'b0) begin errors++; $display("[TB] FAIL single_wen: got %b expected 0", regWen); end
      checks++; if (rd !== 5'd5) begin errors++; $display("[TB] FAIL single_rd: got %0d expected 5", rd); end
      checks++; if (rdData !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL single_data: got %h expected a5a50001", rdData); end
      checks++; if (rs1Pend !== 1'b1) begin errors++; $display("[TB] FAIL single_pend: got %b expected 1", rs1Pend); end
      @(negedge clk);
      checks++; if (regWen !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_wen: got %b expected 1", regWen); end
      checks++; if (rs1Pend !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_pend: got %b expected 0", rs1Pend); end
   endtask

   // Two contended pairs: first EX then LD wins the contended cycle.
   task automatic test_round_robin();
      for (int pass = 0; pass < 2; pass++) begin
         logic [4:0]  firstRd, secondRd;
         logic [31:0] firstData, secondData;
         firstRd    = (pass == 0) ? 5'd3 : 5'd7;
         secondRd   = (pass == 0) ? 5'd7 : 5'd3;
         firstData  = (pass == 0) ? 32'h3333_0003 : 32'h7777_0007;
         secondData = (pass == 0) ? 32'h7777_0007 : 32'h3333_0003;
         @(posedge clk);
         #1 exValid = 1'b1; exRd = 5'd3; exData = 32'h3333_0003;
         ldValid = 1'b1; ldRd = 5'd7; ldData = 32'h7777_0007; rs1 = 5'd3; rs2 = 5'd7;
         @(posedge clk);
         #1 exValid = 1'b0; ldValid = 1'b0;
         @(negedge clk);
         checks++; if (regWen !== 1'b0) begin errors++; $display("[TB] FAIL rr%0d_first_wen: got %b expected 0", pass, regWen); end
         checks++; if (rd !== firstRd) begin errors++; $display("[TB] FAIL rr%0d_first_rd: got %0d expected %0d", pass, rd, firstRd); end
         checks++; if (rdData !== firstData) begin errors++; $display("[TB] FAIL rr%0d_first_data: got %h expected %h", pass, rdData, firstData); end
         checks++; if (exReady !== (pass == 0)) begin errors++; $display("[TB] FAIL rr%0d_ex_ready: got %b expected %b", pass, exReady, pass == 0); end
         checks++; if (ldReady !== (pass == 1)) begin errors++; $display("[TB] FAIL rr%0d_ld_ready: got %b expected %b", pass, ldReady, pass == 1); end
         checks++; if ({rs1Pend, rs2Pend} !== 2'b11) begin errors++; $display("[TB] FAIL rr%0d_pend_both: got %b expected 11", pass, {rs1Pend, rs2Pend}); end
         @(negedge clk);
         checks++; if (regWen !== 1'b0) begin errors++; $display("[TB] FAIL rr%0d_second_wen: got %b expected 0", pass, regWen); end
         checks++; if (rd !== secondRd) begin errors++; $display("[TB] FAIL rr%0d_second_rd: got %0d expected %0d", pass, rd, secondRd); end
         checks++; if (rdData !== secondData) begin errors++; $display("[TB] FAIL rr%0d_second_data: got %h expected %h", pass, rdData, secondData); end
         @(negedge clk);
         checks++; if (regWen !== 1'b1) begin errors++; $display("[TB] FAIL rr%0d_idle_wen: got %b expected 1", pass, regWen); end
      end
   endtask

   // Same destination captured together: LD is older and must land first.
   task automatic test_same_rd();
      logic [31:0] x9;
      x9 = 32'h0;
      @(posedge clk);
      #1 exValid = 1'b1; exRd = 5'd9; exData = 32'h9999_000E;
      ldValid = 1'b1; ldRd = 5'd9; ldData = 32'h9999_000D;
      @(posedge clk);
      #1 exValid = 1'b0; ldValid = 1'b0;
      @(negedge clk);
      if (regWen === 1'b0 && rd === 5'd9) x9 = rdData;
      checks++; if (rdData !== 32'h9999_000D) begin errors++; $display("[TB] FAIL samerd_first_data: got %h expected 9999000d", rdData); end
      checks++; if (rd !== 5'd9) begin errors++; $display("[TB] FAIL samerd_first_rd: got %0d expected 9", rd); end
      @(negedge clk);
      if (regWen === 1'b0 && rd === 5'd9) x9 = rdData;
      checks++; if (regWen !== 1'b0) begin errors++; $display("[TB] FAIL samerd_second_wen: got %b expected 0", regWen); end
      checks++; if (rdData !== 32'h9999_000E) begin errors++; $display("[TB] FAIL samerd_second_data: got %h expected 9999000e", rdData); end
      @(negedge clk);
      checks++; if (x9 !== 32'h9999_000E) begin errors++; $display("[TB] FAIL samerd_final_x9: got %h expected 9999000e", x9); end
      checks++; if (regWen !== 1'b1) begin errors++; $display("[TB] FAIL samerd_idle_wen: got %b expected 1", regWen); end
   endtask

   task automatic test_x0_drop();
      @(posedge clk);
      #1 exValid = 1'b1; exRd = 5'd0; exData = 32'hFFFF_FFFF; rs1 = 5'd0; rs2 = 5'd0;
      @(negedge clk);
      checks++; if (exReady !== 1'b1) begin errors++; $display("[TB] FAIL x0_ready: got %b expected 1", exReady); end
      @(posedge clk);
      #1 exValid = 1'b0;
      @(negedge clk);
      checks++; if (regWen !== 1'b1) begin errors++; $display("[TB] FAIL x0_wen: got %b expected 1", regWen); end
      checks++; if (rdData !== 32'h0) begin errors++; $display("[TB] FAIL x0_data: got %h expected 0", rdData); end
      checks++; if (rs1Pend !== 1'b0) begin errors++; $display("[TB] FAIL x0_pend: got %b expected 0", rs1Pend); end
      checks++; if (exReady !== 1'b1) begin errors++; $display("[TB] FAIL x0_ready_after: got %b expected 1", exReady); end
   endtask

   // Both requesters stream; writes must alternate EX0,LD0,EX1,LD1,... one per cycle.
   task automatic test_back_to_back();
      int          exIdx, ldIdx;
      logic        exAcc, ldAcc;
      logic [4:0]  expRd, heldRd;
      logic [31:0] expData;
      exIdx = 0; ldIdx = 0;
      @(posedge clk);
      #1 exValid = 1'b1; exRd = 5'd1; exData = 32'hE000_0000;
      ldValid = 1'b1; ldRd = 5'd17; ldData = 32'hD000_0000;
      @(negedge clk);
      exAcc = exReady; ldAcc = ldReady;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (exAcc) begin exIdx++; exRd = 5'(1 + exIdx); exData = 32'hE000_0000 + 32'(exIdx); end
         if (ldAcc) begin ldIdx++; ldRd = 5'(17 + ldIdx); ldData = 32'hD000_0000 + 32'(ldIdx); end
         if (k % 2 == 0) begin
            expRd = 5'(1 + k / 2); expData = 32'hE000_0000 + 32'(k / 2); heldRd = 5'(17 + k / 2);
         end else begin
            expRd = 5'(17 + k / 2); expData = 32'hD000_0000 + 32'(k / 2); heldRd = 5'(1 + (k + 1) / 2);
         end
         rs1 = heldRd; rs2 = expRd;
         @(negedge clk);
         checks++; if (regWen !== 1'b0) begin errors++; $display("[TB] FAIL stream%0d_wen: got %b expected 0", k, regWen); end
         checks++; if (rd !== expRd) begin errors++; $display("[TB] FAIL stream%0d_rd: got %0d expected %0d", k, rd, expRd); end
         checks++; if (rdData !== expData) begin errors++; $display("[TB] FAIL stream%0d_data: got %h expected %h", k, rdData, expData); end
         checks++; if (rs1Pend !== 1'b1) begin errors++; $display("[TB] FAIL stream%0d_held_pend: got %b expected 1", k, rs1Pend); end
         checks++; if (rs2Pend !== 1'b1) begin errors++; $display("[TB] FAIL stream%0d_draining_pend: got %b expected 1", k, rs2Pend); end
         exAcc = exReady; ldAcc = ldReady;
      end
      @(posedge clk);
      #1 rstN = 1'b0; exValid = 1'b0; ldValid = 1'b0;
      @(posedge clk);
      #1 rstN = 1'b1;
      @(negedge clk);
      checks++; if (regWen !== 1'b1) begin errors++; $display("[TB] FAIL midreset_wen: got %b expected 1", regWen); end
      checks++; if (rd !== 5'd0) begin errors++; $display("[TB] FAIL midreset_rd: got %0d expected 0", rd); end
      checks++; if ({rs1Pend, rs2Pend} !== 2'b00) begin errors++; $display("[TB] FAIL midreset_pend: got %b expected 00", {rs1Pend, rs2Pend}); end
      checks++; if ({exReady, ldReady} !== 2'b11) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 11", {exReady, ldReady}); end
      @(negedge clk);
      checks++; if (regWen !== 1'b1) begin errors++; $display("[TB] FAIL midreset_noflush: got %b expected 1", regWen); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      $display("[TB] starting rf_wb_arbiter bench");
      test_reset();
      test_single_write();
      test_round_robin();
      test_same_rd();
      test_x0_drop();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
